// File: rtl/lt_result_stats.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lt_result_stats
//
// Collects statistics from the latency tester, which sits directly upstream.
// Each rising edge of `finished` delivers one measurement. A latency of
// 16'hffff marks a timeout and is only counted. Any other latency is added to
// running sums, and the block then recomputes truncated averages with a
// bit-serial restoring divider. The divider runs first on the latency sum,
// then on the stabilization sum.
//
// Ports:
//   clk27        in   27 MHz system clock
//   reset_n      in   asynchronous active-low reset
//   clear        in   synchronous clear of all statistics (highest priority
//                     after reset)
//   finished     in   measurement-complete level from the tester
//   lat_result   in   latency result in 0.01 ms units; 16'hffff = timeout
//   stb_result   in   stabilization result
//   sample_cnt   out  number of valid samples accumulated
//   timeout_cnt  out  number of timed-out measurements, saturating at 255
//   lat_min      out  minimum valid latency
//   lat_max      out  maximum valid latency
//   lat_avg      out  floor(lat_sum / sample_cnt)
//   stb_avg      out  floor(stb_sum / sample_cnt)
//   busy         out  accumulate or division in progress
//   full         out  sample_cnt == MAX_SAMPLES
// -----------------------------------------------------------------------------
module lt_result_stats #(
  parameter int MAX_SAMPLES = 16,
  parameter int CNT_W       = 5
) (
  input  logic             clk27,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             finished,
  input  logic [15:0]      lat_result,
  input  logic [11:0]      stb_result,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [7:0]       timeout_cnt,
  output logic [15:0]      lat_min,
  output logic [15:0]      lat_max,
  output logic [15:0]      lat_avg,
  output logic [11:0]      stb_avg,
  output logic             busy,
  output logic             full
);

  // The sums are wide enough to hold MAX_SAMPLES full-scale values.
  localparam int LAT_DW = 16 + CNT_W;
  localparam int STB_DW = 12 + CNT_W;
  localparam int DC_W   = $clog2(LAT_DW);

  localparam logic [DC_W-1:0]  LAT_LAST = DC_W'(LAT_DW - 1);
  localparam logic [DC_W-1:0]  STB_LAST = DC_W'(STB_DW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_SAMPLES);
  localparam logic [15:0]      LAT_TMO  = 16'hffff;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DIV_LAT = 2'd2,
    DIV_STB = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic              finished_l_reg;
  logic [15:0]       lat_cap_reg, lat_cap_next;
  logic [11:0]       stb_cap_reg, stb_cap_next;
  logic [LAT_DW-1:0] lat_sum_reg, lat_sum_next;
  logic [STB_DW-1:0] stb_sum_reg, stb_sum_next;
  logic [LAT_DW-1:0] quo_reg, quo_next;
  logic [CNT_W:0]    rem_reg, rem_next;
  logic [DC_W-1:0]   div_cnt_reg, div_cnt_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [7:0]        tmo_reg, tmo_next;
  logic [15:0]       min_reg, min_next;
  logic [15:0]       max_reg, max_next;
  logic [15:0]       lat_avg_reg, lat_avg_next;
  logic [11:0]       stb_avg_reg, stb_avg_next;
  logic              busy_reg, busy_next;

  logic              edge_seen;
  logic              is_full;
  logic [LAT_DW-1:0] lat_sum_add;
  logic [STB_DW-1:0] stb_sum_add;

  // Divider datapath signals
  logic              div_msb;
  logic [CNT_W:0]    rem_shift;
  logic [CNT_W:0]    divisor_ext;
  logic              rem_ge;
  logic [CNT_W:0]    rem_sub;
  logic [LAT_DW-1:0] quo_shift;

  assign edge_seen   = finished && !finished_l_reg;
  assign is_full     = (cnt_reg == CNT_MAX);
  assign lat_sum_add = lat_sum_reg + {{CNT_W{1'b0}}, lat_cap_reg};
  assign stb_sum_add = stb_sum_reg + {{CNT_W{1'b0}}, stb_cap_reg};

  // One restoring-division step. The quotient register starts out holding
  // the dividend. Each cycle it shifts out one dividend bit at the top and
  // takes in one quotient bit at the bottom. The stabilization dividend is
  // narrower, so in DIV_STB the bit shifted out is taken from position
  // STB_DW-1. The remainder is always less than the divisor, which is at
  // most MAX_SAMPLES, so after the shift it still fits in CNT_W+1 bits.
  assign div_msb     = (state_reg == DIV_LAT) ? quo_reg[LAT_DW-1] : quo_reg[STB_DW-1];
  assign rem_shift   = {rem_reg[CNT_W-1:0], div_msb};
  assign divisor_ext = {1'b0, cnt_reg};
  assign rem_ge      = (rem_shift >= divisor_ext);
  assign rem_sub     = rem_shift - divisor_ext;
  assign quo_shift   = {quo_reg[LAT_DW-2:0], rem_ge};

  always_comb begin
    state_next   = state_reg;
    lat_cap_next = lat_cap_reg;
    stb_cap_next = stb_cap_reg;
    lat_sum_next = lat_sum_reg;
    stb_sum_next = stb_sum_reg;
    quo_next     = quo_reg;
    rem_next     = rem_reg;
    div_cnt_next = div_cnt_reg;
    cnt_next     = cnt_reg;
    tmo_next     = tmo_reg;
    min_next     = min_reg;
    max_next     = max_reg;
    lat_avg_next = lat_avg_reg;
    stb_avg_next = stb_avg_reg;
    busy_next    = busy_reg;

    if (clear) begin
      // Clear aborts any division in progress and drops any edge seen in
      // the same cycle.
      state_next   = IDLE;
      lat_cap_next = '0;
      stb_cap_next = '0;
      lat_sum_next = '0;
      stb_sum_next = '0;
      quo_next     = '0;
      rem_next     = '0;
      div_cnt_next = '0;
      cnt_next     = '0;
      tmo_next     = '0;
      min_next     = '0;
      max_next     = '0;
      lat_avg_next = '0;
      stb_avg_next = '0;
      busy_next    = 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          // Edges that arrive outside IDLE are dropped. Because finished is
          // a level, such an edge is never seen again later.
          if (edge_seen) begin
            if (lat_result == LAT_TMO) begin
              if (tmo_reg != 8'hff) tmo_next = tmo_reg + 8'd1;
            end else if (!is_full) begin
              lat_cap_next = lat_result;
              stb_cap_next = stb_result;
              busy_next    = 1'b1;
              state_next   = ACCUM;
            end
          end
        end

        ACCUM: begin
          cnt_next     = cnt_reg + CNT_ONE;
          lat_sum_next = lat_sum_add;
          stb_sum_next = stb_sum_add;
          if (cnt_reg == '0) begin
            min_next = lat_cap_reg;
            max_next = lat_cap_reg;
          end else begin
            if (lat_cap_reg < min_reg) min_next = lat_cap_reg;
            if (lat_cap_reg > max_reg) max_next = lat_cap_reg;
          end
          quo_next     = lat_sum_add;
          rem_next     = '0;
          div_cnt_next = '0;
          state_next   = DIV_LAT;
        end

        DIV_LAT: begin
          quo_next     = quo_shift;
          rem_next     = rem_ge ? rem_sub : rem_shift;
          div_cnt_next = div_cnt_reg + 1'b1;
          if (div_cnt_reg == LAT_LAST) begin
            // Sum < 2^16 * sample_cnt, so the upper quotient bits are zero.
            lat_avg_next = quo_shift[15:0];
            quo_next     = {{(LAT_DW-STB_DW){1'b0}}, stb_sum_reg};
            rem_next     = '0;
            div_cnt_next = '0;
            state_next   = DIV_STB;
          end
        end

        DIV_STB: begin
          quo_next     = quo_shift;
          rem_next     = rem_ge ? rem_sub : rem_shift;
          div_cnt_next = div_cnt_reg + 1'b1;
          if (div_cnt_reg == STB_LAST) begin
            stb_avg_next = quo_shift[11:0];
            busy_next    = 1'b0;
            state_next   = IDLE;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      finished_l_reg <= 1'b0;
      lat_cap_reg    <= '0;
      stb_cap_reg    <= '0;
      lat_sum_reg    <= '0;
      stb_sum_reg    <= '0;
      quo_reg        <= '0;
      rem_reg        <= '0;
      div_cnt_reg    <= '0;
      cnt_reg        <= '0;
      tmo_reg        <= '0;
      min_reg        <= '0;
      max_reg        <= '0;
      lat_avg_reg    <= '0;
      stb_avg_reg    <= '0;
      busy_reg       <= 1'b0;
    end else begin
      finished_l_reg <= finished;
      lat_cap_reg    <= lat_cap_next;
      stb_cap_reg    <= stb_cap_next;
      lat_sum_reg    <= lat_sum_next;
      stb_sum_reg    <= stb_sum_next;
      quo_reg        <= quo_next;
      rem_reg        <= rem_next;
      div_cnt_reg    <= div_cnt_next;
      cnt_reg        <= cnt_next;
      tmo_reg        <= tmo_next;
      min_reg        <= min_next;
      max_reg        <= max_next;
      lat_avg_reg    <= lat_avg_next;
      stb_avg_reg    <= stb_avg_next;
      busy_reg       <= busy_next;
    end
  end

  assign sample_cnt  = cnt_reg;
  assign timeout_cnt = tmo_reg;
  assign lat_min     = min_reg;
  assign lat_max     = max_reg;
  assign lat_avg     = lat_avg_reg;
  assign stb_avg     = stb_avg_reg;
  assign busy        = busy_reg;
  assign full        = is_full;

endmodule

// File: tb/tb_lt_result_stats.sv
`timescale 1ns/1ps
// Directed testbench for lt_result_stats. Inputs change on the falling edge
// and outputs are sampled on the falling edge.
module tb_lt_result_stats;

  localparam int MAX_SAMPLES = 16;
  localparam int CNT_W       = 5;

  logic             clk27;
  logic             reset_n;
  logic             clear;
  logic             finished;
  logic [15:0]      lat_result;
  logic [11:0]      stb_result;
  logic [CNT_W-1:0] sample_cnt;
  logic [7:0]       timeout_cnt;
  logic [15:0]      lat_min;
  logic [15:0]      lat_max;
  logic [15:0]      lat_avg;
  logic [11:0]      stb_avg;
  logic             busy;
  logic             full;

  int vec_cnt    = 0;
  int miscompares = 0;

  lt_result_stats #(
    .MAX_SAMPLES(MAX_SAMPLES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk27      (clk27),
    .reset_n    (reset_n),
    .clear      (clear),
    .finished   (finished),
    .lat_result (lat_result),
    .stb_result (stb_result),
    .sample_cnt (sample_cnt),
    .timeout_cnt(timeout_cnt),
    .lat_min    (lat_min),
    .lat_max    (lat_max),
    .lat_avg    (lat_avg),
    .stb_avg    (stb_avg),
    .busy       (busy),
    .full       (full)
  );

  initial clk27 = 1'b0;
  always #18 clk27 = ~clk27;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %-22s observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_stats(input string tag, input int cnt, input int mn, input int mx,
                           input int la, input int sa);
    chk({tag, ".cnt"}, 32'(sample_cnt), 32'(cnt));
    chk({tag, ".min"}, 32'(lat_min), 32'(mn));
    chk({tag, ".max"}, 32'(lat_max), 32'(mx));
    chk({tag, ".lat_avg"}, 32'(lat_avg), 32'(la));
    chk({tag, ".stb_avg"}, 32'(stb_avg), 32'(sa));
  endtask

  // Presents one measurement and watches 100 cycles. kind 0: plain sample.
  // kind 1: pulse clear on busy cycle act_at. kind 2: drop finished for two
  // cycles at busy cycle 10, then hold it high again (edge while busy).
  task automatic run_sample(input logic [15:0] lat, input logic [11:0] stb,
                            input int kind, input int act_at,
                            output int busy_n, output logic [15:0] lat22,
                            output logic [15:0] lat23, output logic [11:0] stb23);
    busy_n     = 0;
    lat22      = '0;
    lat23      = '0;
    stb23      = '0;
    lat_result = lat;
    stb_result = stb;
    finished   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk27);
      clear = 1'b0;
      if (i == 3 && kind != 2) finished = 1'b0;
      if (busy) begin
        busy_n++;
        if (busy_n == 22) lat22 = lat_avg;
        if (busy_n == 23) begin
          lat23 = lat_avg;
          stb23 = stb_avg;
        end
        if (kind == 1 && busy_n == act_at) clear = 1'b1;
        if (kind == 2 && busy_n == 10) finished = 1'b0;
        if (kind == 2 && busy_n == 12) finished = 1'b1;
      end
    end
    finished = 1'b0;
    clear    = 1'b0;
    repeat (2) @(negedge clk27);
    $display("sample lat=%0d stb=%0d kind=%0d busy_cycles=%0d", lat, stb, kind, busy_n);
  endtask

  task automatic pulse_timeout();
    lat_result = 16'hffff;
    finished   = 1'b1;
    @(negedge clk27);
    finished   = 1'b0;
    @(negedge clk27);
  endtask

  initial begin
    int          bn;
    logic [15:0] l22, l23;
    logic [11:0] s23;

    reset_n    = 1'b0;
    clear      = 1'b0;
    finished   = 1'b0;
    lat_result = '0;
    stb_result = '0;
    repeat (3) @(negedge clk27);
    reset_n = 1'b1;
    @(negedge clk27);

    // 1. Reset state
    chk_stats("reset", 0, 0, 0, 0, 0);
    chk("reset.tmo", 32'(timeout_cnt), 0);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.full", 32'(full), 0);

    // 1b. Reset asserted in the middle of DIV_LAT
    lat_result = 16'd1000;
    stb_result = 12'd50;
    finished   = 1'b1;
    repeat (10) @(negedge clk27);
    chk("midrst.busy_before", 32'(busy), 1);
    chk("midrst.cnt_before", 32'(sample_cnt), 1);
    #2;
    reset_n  = 1'b0;
    finished = 1'b0;
    #1;
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.lat_avg", 32'(lat_avg), 0);
    chk("midrst.cnt", 32'(sample_cnt), 0);
    @(negedge clk27);
    reset_n = 1'b1;
    repeat (60) @(negedge clk27);
    chk("midrst.busy_after", 32'(busy), 0);
    chk("midrst.lat_avg_after", 32'(lat_avg), 0);
    chk("midrst.stb_avg_after", 32'(stb_avg), 0);
    chk("midrst.cnt_after", 32'(sample_cnt), 0);

    // 2. Three valid samples
    run_sample(16'd100, 12'd120, 0, 0, bn, l22, l23, s23);
    chk("s1.busy_cycles", 32'(bn), 39);
    chk_stats("s1", 1, 100, 100, 100, 120);
    run_sample(16'd200, 12'd130, 0, 0, bn, l22, l23, s23);
    chk("s2.busy_cycles", 32'(bn), 39);
    chk_stats("s2", 2, 100, 200, 150, 125);
    run_sample(16'd301, 12'd141, 0, 0, bn, l22, l23, s23);
    chk("s3.busy_cycles", 32'(bn), 39);
    chk("s3.lat_avg_at22", 32'(l22), 150);
    chk("s3.lat_avg_at23", 32'(l23), 200);
    chk("s3.stb_avg_at23", 32'(s23), 125);
    chk_stats("s3", 3, 100, 301, 200, 130);

    // 3. Timeouts
    run_sample(16'hffff, 12'd0, 0, 0, bn, l22, l23, s23);
    chk("tmo.busy_cycles", 32'(bn), 0);
    chk("tmo.count1", 32'(timeout_cnt), 1);
    chk_stats("tmo", 3, 100, 301, 200, 130);
    for (int k = 0; k < 254; k++) pulse_timeout();
    chk("tmo.count255", 32'(timeout_cnt), 255);
    pulse_timeout();
    chk("tmo.count256_sat", 32'(timeout_cnt), 255);

    // Clear from idle
    @(negedge clk27);
    clear = 1'b1;
    @(negedge clk27);
    clear = 1'b0;
    chk_stats("clr", 0, 0, 0, 0, 0);
    chk("clr.tmo", 32'(timeout_cnt), 0);

    // 4. Saturation at MAX_SAMPLES
    for (int k = 0; k < 17; k++) begin
      run_sample(16'd500, 12'd150, 0, 0, bn, l22, l23, s23);
      chk($sformatf("fill%0d.busy_cycles", k), 32'(bn), (k < 16) ? 32'd39 : 32'd0);
      if (k == 14) chk("fill14.full", 32'(full), 0);
    end
    chk("fill.full", 32'(full), 1);
    chk_stats("fill", 16, 500, 500, 500, 150);

    // 5. Clear during busy
    @(negedge clk27);
    clear = 1'b1;
    @(negedge clk27);
    clear = 1'b0;
    chk("clr2.full", 32'(full), 0);
    run_sample(16'd1000, 12'd60, 1, 10, bn, l22, l23, s23);
    chk("clrbusy.busy_cycles", 32'(bn), 10);
    chk("clrbusy.busy", 32'(busy), 0);
    chk_stats("clrbusy", 0, 0, 0, 0, 0);
    run_sample(16'd42, 12'd7, 0, 0, bn, l22, l23, s23);
    chk("s42.busy_cycles", 32'(bn), 39);
    chk_stats("s42", 1, 42, 42, 42, 7);

    // 6. Second edge while busy is dropped
    run_sample(16'd80, 12'd9, 2, 0, bn, l22, l23, s23);
    chk("edgebusy.busy_cycles", 32'(bn), 39);
    chk_stats("edgebusy", 2, 42, 80, 61, 8);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
